// File: rtl/math_computer_arbiter.sv
// Round-robin share of one math_computer between NB_REQ requesters; 0-cycle issue and return paths, in-order tag FIFO.
// Issue stalls on full tag FIFO or mc_ready low (grant locked); results stall on rsp_ready of head tag. MATH_ARB_ASSERT_EN adds assertions.

module math_arb_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = (count_o == (AW+1)'(DEPTH));
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d   = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d   = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end
endmodule

module math_computer_arbiter #(
    parameter int NB_REQ    = 4,
    parameter int DATASIZE  = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NB_REQ-1:0]              req_valid,
    input  logic [NB_REQ*DATASIZE-1:0]     req_a,
    input  logic [NB_REQ*DATASIZE-1:0]     req_b,
    input  logic [NB_REQ*DATASIZE-1:0]     req_c,
    output logic [NB_REQ-1:0]              req_ready,
    output logic                           mc_valid,
    output logic [DATASIZE-1:0]            mc_a,
    output logic [DATASIZE-1:0]            mc_b,
    output logic [DATASIZE-1:0]            mc_c,
    input  logic                           mc_ready,
    input  logic                           mc_res_valid,
    input  logic [DATASIZE-1:0]            mc_res,
    output logic                           mc_res_ready,
    output logic [NB_REQ-1:0]              rsp_valid,
    output logic [DATASIZE-1:0]            rsp_result,
    input  logic [NB_REQ-1:0]              rsp_ready,
    output logic [$clog2(TAG_DEPTH):0]     outstanding,
    output logic                           err_orphan
);
    localparam int IDX_W = $clog2(NB_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_REQ - 1);

    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                lock_q, lock_d;
    logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
    logic                err_orphan_q, err_orphan_d;

    logic [DATASIZE-1:0] op_a [NB_REQ];
    logic [DATASIZE-1:0] op_b [NB_REQ];
    logic [DATASIZE-1:0] op_c [NB_REQ];

    logic [IDX_W:0]      cand;
    logic                arb_found;
    logic [IDX_W-1:0]    arb_idx;
    logic [IDX_W-1:0]    win_idx;
    logic                any_req;
    logic                issue_hs;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IDX_W-1:0]    head_tag;
    logic                res_pop;

    always_comb begin
        for (int i = 0; i < NB_REQ; i++) begin
            op_a[i] = req_a[i*DATASIZE +: DATASIZE];
            op_b[i] = req_b[i*DATASIZE +: DATASIZE];
            op_c[i] = req_c[i*DATASIZE +: DATASIZE];
        end
    end

    // Search starts at the priority pointer and wraps modulo NB_REQ.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NB_REQ)) begin
                cand = cand - (IDX_W+1)'(NB_REQ);
            end
            if (!arb_found && req_valid[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign win_idx  = lock_q ? lock_idx_q : arb_idx;
    assign any_req  = |req_valid;
    assign mc_valid = any_req && !fifo_full;
    assign issue_hs = mc_valid && mc_ready;

    always_comb begin
        req_ready = '0;
        mc_a      = '0;
        mc_b      = '0;
        mc_c      = '0;
        if (any_req) begin
            mc_a = op_a[win_idx];
            mc_b = op_b[win_idx];
            mc_c = op_c[win_idx];
        end
        if (issue_hs) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // An empty FIFO means nobody owns the result: accept and drop it.
    always_comb begin
        rsp_valid    = '0;
        mc_res_ready = 1'b0;
        res_pop      = 1'b0;
        if (fifo_empty) begin
            mc_res_ready = mc_res_valid;
        end else begin
            rsp_valid[head_tag] = mc_res_valid;
            mc_res_ready        = rsp_ready[head_tag];
            res_pop             = mc_res_valid && rsp_ready[head_tag];
        end
    end

    assign rsp_result = mc_res;
    assign err_orphan = err_orphan_q;

    always_comb begin
        ptr_d        = ptr_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        err_orphan_d = err_orphan_q || (fifo_empty && mc_res_valid);
        if (issue_hs) begin
            ptr_d  = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            lock_d = 1'b0;
        end else if (mc_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    math_arb_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (issue_hs),
        .push_dat_i (win_idx),
        .pop_i      (res_pop),
        .head_dat_o (head_tag),
        .count_o    (outstanding),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

`ifdef MATH_ARB_ASSERT_EN
    a_issue_hold: assert property (@(posedge clk) disable iff (rst)
        (mc_valid && !mc_ready) |=> (mc_valid && (win_idx == $past(win_idx))));
    a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(rsp_valid));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(issue_hs && fifo_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(res_pop && fifo_empty));
    a_no_orphan: assert property (@(posedge clk) disable iff (rst)
        !$rose(err_orphan));
`endif
endmodule

// File: tb/tb_math_computer_arbiter.sv
// Directed vector bench for math_computer_arbiter (NB_REQ=4, DATASIZE=16, TAG_DEPTH=4).
module tb_math_computer_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b, req_c;
    logic [3:0]  req_ready;
    logic        mc_valid;
    logic [15:0] mc_a, mc_b, mc_c;
    logic        mc_ready;
    logic        mc_res_valid;
    logic [15:0] mc_res;
    logic        mc_res_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_ready;
    logic [2:0]  outstanding;
    logic        err_orphan;

    int checks   = 0;
    int failures = 0;

    math_computer_arbiter #(
        .NB_REQ    (4),
        .DATASIZE  (16),
        .TAG_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .req_ready    (req_ready),
        .mc_valid     (mc_valid),
        .mc_a         (mc_a),
        .mc_b         (mc_b),
        .mc_c         (mc_c),
        .mc_ready     (mc_ready),
        .mc_res_valid (mc_res_valid),
        .mc_res       (mc_res),
        .mc_res_ready (mc_res_ready),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .rsp_ready    (rsp_ready),
        .outstanding  (outstanding),
        .err_orphan   (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic        rdy;
        logic        rv;
        logic [15:0] res;
        logic [3:0]  rr;
        logic [3:0]  e_rq;
        logic        e_mcv;
        logic [15:0] e_a;
        logic [3:0]  e_rv;
        logic        e_mrr;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rdy,
                                input logic rv, input logic [15:0] res, input logic [3:0] rr,
                                input logic [3:0] e_rq, input logic e_mcv, input logic [15:0] e_a,
                                input logic [3:0] e_rv, input logic e_mrr, input logic [2:0] e_out,
                                input logic e_err);
        vec_t t;
        t.rst = r; t.v = v; t.rdy = rdy; t.rv = rv; t.res = res; t.rr = rr;
        t.e_rq = e_rq; t.e_mcv = e_mcv; t.e_a = e_a; t.e_rv = e_rv;
        t.e_mrr = e_mrr; t.e_out = e_out; t.e_err = e_err;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        bit found;
        // Requester i operands: a=i+1, b=i+2, c=i+3 (requester 2 -> 3,4,5).
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(i + 1);
            req_b[i*16 +: 16] = 16'(i + 2);
            req_c[i*16 +: 16] = 16'(i + 3);
        end
        rst = 1'b1; req_valid = '0; mc_ready = 1'b0;
        mc_res_valid = 1'b0; mc_res = '0; rsp_ready = '0;

        //                r  v        rdy rv res       rr         e_rq     mcv e_a e_rv     mrr out err
        vecs.push_back(mk(0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 16'h0000, 4'b0000, 4'b0100, 1, 3, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 16'h0BEE, 4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 4, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 16'h0000, 4'b0000, 4'b1000, 1, 4, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 16'h0000, 4'b0000, 4'b0001, 1, 1, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 1, 16'h3333, 4'b1111, 4'b0010, 1, 2, 4'b1000, 1, 2, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 1, 16'h1000, 4'b1111, 4'b0100, 1, 3, 4'b0001, 1, 2, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 1, 16'h1001, 4'b1111, 4'b1000, 1, 4, 4'b0010, 1, 2, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 1, 16'h1002, 4'b1111, 4'b0001, 1, 1, 4'b0100, 1, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 16'h1003, 4'b1111, 4'b0000, 0, 0, 4'b1000, 1, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 16'h1004, 4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 1, 0));
        // Requesters 1 and 3 with mc_ready low for three cycles.
        vecs.push_back(mk(0, 4'b1010, 0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 2, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1010, 0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 2, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1010, 0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 2, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1010, 1, 0, 16'h0000, 4'b0000, 4'b0010, 1, 2, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 1, 0, 16'h0000, 4'b0000, 4'b1000, 1, 4, 4'b0000, 0, 1, 0));
        // Lock on 3 must survive requester 0 appearing at higher priority.
        vecs.push_back(mk(0, 4'b1000, 0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 4, 4'b0000, 0, 2, 0));
        vecs.push_back(mk(0, 4'b1001, 0, 0, 16'h0000, 4'b0000, 4'b0000, 1, 4, 4'b0000, 0, 2, 0));
        vecs.push_back(mk(0, 4'b1001, 1, 0, 16'h0000, 4'b0000, 4'b1000, 1, 4, 4'b0000, 0, 2, 0));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 16'h0000, 4'b0000, 4'b0001, 1, 1, 4'b0000, 0, 3, 0));
        // Full FIFO: no issue, not even on the popping cycle.
        vecs.push_back(mk(0, 4'b1111, 1, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 1, 16'h2001, 4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 4, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 16'h0000, 4'b0000, 4'b0010, 1, 2, 4'b0000, 0, 3, 0));
        // Head requester 3 stalls its response for two cycles.
        vecs.push_back(mk(0, 4'b0000, 0, 1, 16'h3003, 4'b0111, 4'b0000, 0, 0, 4'b1000, 0, 4, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 16'h3003, 4'b0111, 4'b0000, 0, 0, 4'b1000, 0, 4, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 16'h3003, 4'b1000, 4'b0000, 0, 0, 4'b1000, 1, 4, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 16'h3004, 4'b1111, 4'b0000, 0, 0, 4'b1000, 1, 3, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 16'h3005, 4'b1111, 4'b0000, 0, 0, 4'b0001, 1, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 16'h3006, 4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 1, 0));
        // Orphan result, sticky error, cleared only by reset.
        vecs.push_back(mk(0, 4'b0000, 0, 1, 16'h0DEA, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
        // Reset with one tag outstanding; the late result becomes an orphan.
        vecs.push_back(mk(0, 4'b0001, 1, 0, 16'h0000, 4'b0000, 4'b0001, 1, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 16'h0BAD, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0011, 1, 0, 16'h0000, 4'b0000, 4'b0001, 1, 1, 4'b0000, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].rst;
            req_valid    = vecs[i].v;
            mc_ready     = vecs[i].rdy;
            mc_res_valid = vecs[i].rv;
            mc_res       = vecs[i].res;
            rsp_ready    = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("r%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rq));
            chk($sformatf("r%0d_mc_valid", i), 32'(mc_valid), 32'(vecs[i].e_mcv));
            chk($sformatf("r%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            chk($sformatf("r%0d_mc_res_ready", i), 32'(mc_res_ready), 32'(vecs[i].e_mrr));
            chk($sformatf("r%0d_outstanding", i), 32'(outstanding), 32'(vecs[i].e_out));
            chk($sformatf("r%0d_err_orphan", i), 32'(err_orphan), 32'(vecs[i].e_err));
            if (vecs[i].e_mcv) begin
                chk($sformatf("r%0d_mc_a", i), 32'(mc_a), 32'(vecs[i].e_a));
                chk($sformatf("r%0d_mc_b", i), 32'(mc_b), 32'(vecs[i].e_a + 16'd1));
                chk($sformatf("r%0d_mc_c", i), 32'(mc_c), 32'(vecs[i].e_a + 16'd2));
            end
            if (vecs[i].rv) begin
                chk($sformatf("r%0d_rsp_result", i), 32'(rsp_result), 32'(vecs[i].res));
            end
            @(posedge clk);
            #1;
        end

        // Fresh reset: operand mux idles at zero.
        rst = 1'b1; req_valid = '0; mc_ready = 1'b0;
        mc_res_valid = 1'b0; mc_res = '0; rsp_ready = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mc_a", 32'(mc_a), 32'd0);
        chk("rst_mc_b", 32'(mc_b), 32'd0);
        chk("rst_mc_c", 32'(mc_c), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err_orphan", 32'(err_orphan), 32'd0);

        // Requester 2 alone with a=3,b=4,c=5 granted within a bounded window.
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        mc_ready  = 1'b1;
        found     = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk);
            if (req_ready == 4'b0100) begin
                found = 1'b1;
                chk("solo_mc_a", 32'(mc_a), 32'd3);
                chk("solo_mc_b", 32'(mc_b), 32'd4);
                chk("solo_mc_c", 32'(mc_c), 32'd5);
            end
        end
        chk("solo_grant_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        mc_ready  = 1'b0;
        @(negedge clk);
        chk("solo_outstanding", 32'(outstanding), 32'd1);
        mc_res_valid = 1'b1;
        mc_res       = 16'h00C5;
        rsp_ready    = 4'b0100;
        #1;
        chk("solo_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("solo_rsp_result", 32'(rsp_result), 32'h00C5);
        @(posedge clk);
        #1;
        mc_res_valid = 1'b0;
        rsp_ready    = '0;
        @(negedge clk);
        chk("solo_drained", 32'(outstanding), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/math_computer_arbiter.md
# math_computer_arbiter

Round-robin arbiter that shares one `math_computer` instance between `NB_REQ` requesters. It owns the computer's input port, forwards one requester's operands at a time, and records the winning requester index in an in-order tag FIFO. Results leaving the computer's output port are steered back to the requester at the head of that FIFO. The block sits between the requester-side valid/ready ports and the `math_computer` input and output interfaces.

## Interface
Parameters:
- `NB_REQ`, 4, number of requesters (2..16)
- `DATASIZE`, 16, operand and result width
- `TAG_DEPTH`, 4, maximum outstanding transactions (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NB_REQ  per-requester operand valid
- `req_a`, `req_b`, `req_c`  in  NB_REQ×DATASIZE  packed operands, slice i belongs to requester i
- `req_ready`  out  NB_REQ  per-requester accept
- `mc_valid`  out  1  to computer input port valid
- `mc_a`, `mc_b`, `mc_c`  out  DATASIZE  operands to computer
- `mc_ready`  in  1  computer input port ready
- `mc_res_valid`  in  1  computer output port valid
- `mc_res`  in  DATASIZE  computer result
- `mc_res_ready`  out  1  to computer output port ready
- `rsp_valid`  out  NB_REQ  per-requester result valid (one-hot or zero)
- `rsp_result`  out  DATASIZE  result, shared by all requesters
- `rsp_ready`  in  NB_REQ  per-requester result accept
- `outstanding`  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy
- `err_orphan`  out  1  sticky: result received with tag FIFO empty

## Operation
- Transfer rule: a handshake occurs when valid and ready are both high on a rising edge. Requesters must hold `req_valid` and operands stable until they see `req_ready`.
- Arbitration:
  - Priority pointer `ptr` (0..NB_REQ-1).
  - Winner = first i with `req_valid[i]`, searching ptr, ptr+1, … modulo NB_REQ.
- Issue (combinational mux):
  - `mc_valid` = (any request) && !fifo_full.
  - `mc_a/b/c` = winner operands.
  - `req_ready[winner]` = `mc_ready` && !fifo_full; all other `req_ready` bits are 0.
- Lock:
  - If `mc_valid` is high and `mc_ready` is low, the winner index is registered.
  - Next cycle the grant stays on that index regardless of the other requests.
  - The lock clears on the handshake.
- On input handshake of requester i:
  - Push i into the tag FIFO.
  - `ptr` ← (i+1) mod NB_REQ.
- Response steering:
  - h = FIFO head tag.
  - `rsp_valid[h]` = `mc_res_valid`; `rsp_result` = `mc_res`.
  - `mc_res_ready` = `rsp_ready[h]`.
  - Pop the FIFO on the output handshake.
- Orphan result (FIFO empty with `mc_res_valid` high):
  - `mc_res_ready` = 1, so the result is dropped.
  - All `rsp_valid` = 0.
  - `err_orphan` sets and holds until reset.
- Full FIFO: no new issue, even if a pop occurs in the same cycle. The issue path depends only on registered occupancy.
- Push and pop in the same cycle (not full): occupancy unchanged, FIFO order preserved.

## Timing
- Reset values:
  - `ptr`=0, lock clear, FIFO empty, `outstanding`=0, `err_orphan`=0.
  - All combinational outputs evaluate to 0 while the FIFO is empty and no request is pending.
  - `rst` taking priority mid-transaction discards all tags. Results already inside the computer then surface as orphans. The integrator also resets the computer on the same `rst`.
- Latency:
  - Requester → computer input: 0 cycles (combinational). The arbiter adds no register stage.
  - Computer output → requester: 0 cycles.
- Throughput: one issue per cycle while not full; one result per cycle.
- Occupancy: `outstanding` and `ptr` update on the clock edge following the handshake.
- Wrap-around:
  - `ptr` wraps NB_REQ-1 → 0.
  - FIFO read and write pointers wrap modulo TAG_DEPTH, with one extra bit for full/empty distinction.

## Configuration
- `MATH_ARB_ASSERT_EN` defined: the block compiles in concurrent assertions, all clocked on `clk` and disabled during `rst`:
  - `mc_valid && !mc_ready |=> mc_valid` with unchanged winner.
  - `req_ready` is at most one-hot.
  - `rsp_valid` is at most one-hot.
  - No push while full.
  - No pop while empty.
  - `err_orphan` never rises.
- Undefined: no assertion code. Functional behaviour, including `err_orphan`, is identical.

## Test plan
- Reset, then request 2 alone with a=3, b=4, c=5, `mc_ready`=1 → `req_ready`=4'b0100 in the same cycle; `outstanding`=1 and `ptr`=3 next cycle; the result routes to `rsp_valid`=4'b0100.
- All four requesters valid continuously, `mc_ready`=1, results returned 2 cycles later → grant order 0,1,2,3,0 once each per round; responses return in order 0,1,2,3.
- Requesters 1 and 3 valid, `mc_ready` low for 3 cycles → `mc_a/b/c` and grant stay on requester 1 all 3 cycles; requester 1 is accepted when ready rises; requester 3 is granted next.
- Issue 4 requests with no results (TAG_DEPTH=4) → `outstanding`=4, `mc_valid`=0 with requesters still valid; one result popped → issue resumes the following cycle.
- `mc_res_valid`=1 with an empty FIFO → `mc_res_ready`=1, `rsp_valid`=0, `err_orphan`=1 from the next cycle, held until `rst`.
- `rsp_ready[h]`=0 for 2 cycles → `mc_res_ready`=0, the FIFO head is retained, and `rsp_result` is stable.
